// File: rtl/mdio_slave_regfile_if.sv
// MDIO bus signals between the station-management master and the slave.
// The effective bus bit is mdio_oe ? mdio_out : 1 (pull-up).
interface mdio_slave_regfile_if;
  logic mdio_out;
  logic mdio_oe;
  logic mdio_in;
  logic slave_oe;

  modport master (output mdio_out, output mdio_oe, input mdio_in, input slave_oe);
  modport slave  (input mdio_out, input mdio_oe, output mdio_in, output slave_oe);
endinterface

// File: rtl/mdio_slave_regfile.sv
// Clause-22 MDIO slave: decodes serial management frames and services reads
// and writes against a local file of NUM_REGS 16-bit registers.
module mdio_slave_regfile #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned MIN_PREAMBLE = 32,
  parameter bit          BCAST_EN     = 1'b1,
  parameter int unsigned ERR_W        = 8
) (
  input  logic                     mdc,
  input  logic                     rst,
  mdio_slave_regfile_if.slave      bus,
  output logic [16*NUM_REGS-1:0]   reg_q,
  output logic                     wr_strobe,
  output logic [4:0]               wr_addr,
  output logic [15:0]              wr_data,
  output logic                     busy,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int unsigned         PRE_W   = (MIN_PREAMBLE > 0) ? $clog2(MIN_PREAMBLE + 1) : 1;
  localparam logic [PRE_W-1:0]    PRE_MIN = PRE_W'(MIN_PREAMBLE);
  localparam logic [5:0]          NREG6   = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    ST1,
    OP,
    ADDR,
    WTA,
    WDATA,
    RDATA
  } state_e;

  state_e                       state_q, state_d;
  logic [PRE_W-1:0]             pre_cnt_q, pre_cnt_d;
  logic [4:0]                   bit_cnt_q, bit_cnt_d;
  logic [15:0]                  shift_q, shift_d;
  logic                         is_wr_q, is_wr_d;
  logic                         match_q, match_d;
  logic                         valid_q, valid_d;
  logic [4:0]                   regad_q, regad_d;
  logic [NUM_REGS-1:0][15:0]    regs_q, regs_d;
  logic                         wr_strobe_q, wr_strobe_d;
  logic [4:0]                   wr_addr_q, wr_addr_d;
  logic [15:0]                  wr_data_q, wr_data_d;
  logic [ERR_W-1:0]             err_cnt_q, err_cnt_d;
  logic                         mdio_in_q, mdio_in_d;
  logic                         slave_oe_q, slave_oe_d;

  logic                         b;
  logic                         err_inc;
  logic [15:0]                  frame_bits;
  logic [4:0]                   phyad_in;
  logic [4:0]                   regad_in;
  logic [15:0]                  rdata;

  assign b          = bus.mdio_oe ? bus.mdio_out : 1'b1;
  // Shift register including the bit being sampled on this edge.
  assign frame_bits = {shift_q[14:0], b};
  assign phyad_in   = frame_bits[9:5];
  assign regad_in   = frame_bits[4:0];

  // Unimplemented addresses match no entry and read back as zero.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (regad_in == 5'(i)) rdata = regs_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q + 5'd1;
    shift_d     = frame_bits;
    is_wr_d     = is_wr_q;
    match_d     = match_q;
    valid_d     = valid_q;
    regad_d     = regad_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mdio_in_d   = mdio_in_q;
    slave_oe_d  = slave_oe_q;
    err_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = 5'd1;
        if (b) begin
          if (pre_cnt_q < PRE_MIN) pre_cnt_d = pre_cnt_q + 1'b1;
        end else begin
          pre_cnt_d = '0;
          if (pre_cnt_q >= PRE_MIN) state_d = ST1;
        end
      end
      ST1: begin
        if (b) begin
          state_d = OP;
        end else begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      OP: begin
        if (bit_cnt_q == 5'd3) begin
          case (frame_bits[1:0])
            2'b01: begin is_wr_d = 1'b1; state_d = ADDR; end
            2'b10: begin is_wr_d = 1'b0; state_d = ADDR; end
            default: begin err_inc = 1'b1; state_d = IDLE; end
          endcase
        end
      end
      ADDR: begin
        if (bit_cnt_q == 5'd13) begin
          regad_d = regad_in;
          match_d = (phyad_in == PHY_ADDR) || (BCAST_EN && is_wr_q && (phyad_in == 5'd0));
          valid_d = {1'b0, regad_in} < NREG6;
          if (is_wr_q) begin
            state_d = WTA;
          end else begin
            state_d = RDATA;
            shift_d = rdata;
          end
        end
      end
      WTA: begin
        if (bit_cnt_q == 5'd15) begin
          if (frame_bits[1:0] == 2'b10) begin
            state_d = WDATA;
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WDATA: begin
        if (bit_cnt_q == 5'd31) begin
          state_d = IDLE;
          if (match_q && valid_q) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (regad_q == 5'(i)) regs_d[i] = frame_bits;
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = regad_q;
            wr_data_d   = frame_bits;
          end
        end
      end
      RDATA: begin
        // Bus input is ignored here; shift_q holds the latched read data.
        shift_d = shift_q;
        if (bit_cnt_q == 5'd14) begin
          slave_oe_d = match_q;
          mdio_in_d  = 1'b0;
        end else if (bit_cnt_q == 5'd31) begin
          slave_oe_d = 1'b0;
          mdio_in_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          mdio_in_d = match_q & shift_q[15];
          shift_d   = {shift_q[14:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge mdc or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      is_wr_q     <= 1'b0;
      match_q     <= 1'b0;
      valid_q     <= 1'b0;
      regad_q     <= '0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_cnt_q   <= '0;
      mdio_in_q   <= 1'b0;
      slave_oe_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      is_wr_q     <= is_wr_d;
      match_q     <= match_d;
      valid_q     <= valid_d;
      regad_q     <= regad_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_cnt_q   <= err_cnt_d;
      mdio_in_q   <= mdio_in_d;
      slave_oe_q  <= slave_oe_d;
    end
  end

  assign reg_q        = regs_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign err_cnt      = err_cnt_q;
  assign busy         = (state_q != IDLE);
  assign bus.mdio_in  = mdio_in_q;
  assign bus.slave_oe = slave_oe_q;

endmodule

// File: tb/tb_mdio_slave_regfile.sv
// Bench for mdio_slave_regfile: three instances (default, no preamble,
// 2-bit error counter) share one serial stimulus stream.
module tb_mdio_slave_regfile;
  localparam int unsigned NR = 8;

  logic mdc = 1'b0;
  logic rst = 1'b0;
  logic m_out = 1'b1;
  logic m_oe = 1'b0;

  always #5 mdc = ~mdc;

  mdio_slave_regfile_if bus_m ();
  mdio_slave_regfile_if bus_np ();
  mdio_slave_regfile_if bus_e2 ();
  assign bus_m.mdio_out  = m_out;
  assign bus_m.mdio_oe   = m_oe;
  assign bus_np.mdio_out = m_out;
  assign bus_np.mdio_oe  = m_oe;
  assign bus_e2.mdio_out = m_out;
  assign bus_e2.mdio_oe  = m_oe;

  logic [16*NR-1:0] reg_q_m, reg_q_np, reg_q_e2;
  logic             wr_strobe_m, wr_strobe_np, wr_strobe_e2;
  logic [4:0]       wr_addr_m, wr_addr_np, wr_addr_e2;
  logic [15:0]      wr_data_m, wr_data_np, wr_data_e2;
  logic             busy_m, busy_np, busy_e2;
  logic [7:0]       err_m, err_np;
  logic [1:0]       err_e2;

  mdio_slave_regfile dut_m (
    .mdc(mdc), .rst(rst), .bus(bus_m), .reg_q(reg_q_m), .wr_strobe(wr_strobe_m),
    .wr_addr(wr_addr_m), .wr_data(wr_data_m), .busy(busy_m), .err_cnt(err_m));

  mdio_slave_regfile #(.MIN_PREAMBLE(0)) dut_np (
    .mdc(mdc), .rst(rst), .bus(bus_np), .reg_q(reg_q_np), .wr_strobe(wr_strobe_np),
    .wr_addr(wr_addr_np), .wr_data(wr_data_np), .busy(busy_np), .err_cnt(err_np));

  mdio_slave_regfile #(.ERR_W(2)) dut_e2 (
    .mdc(mdc), .rst(rst), .bus(bus_e2), .reg_q(reg_q_e2), .wr_strobe(wr_strobe_e2),
    .wr_addr(wr_addr_e2), .wr_data(wr_data_e2), .busy(busy_e2), .err_cnt(err_e2));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state for the default-parameter instance.
  logic [15:0] m_regs [32];
  int          m_err;
  logic        e_write, e_oe;
  logic [15:0] e_rdata;

  // Observations gathered while a frame is driven.
  int          o_oe_cnt, o_strobe_cnt, o_np_strobe;
  logic        o_lead, o_busy_end;
  logic [15:0] o_rd, o_wr_data, o_np_data;
  logic [4:0]  o_wr_addr, o_np_addr;

  function automatic logic [16*NR-1:0] model_vec();
    logic [16*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[16*i +: 16] = m_regs[i];
    return v;
  endfunction

  function automatic logic [7:0] exp_err8();
    return (m_err > 255) ? 8'd255 : 8'(m_err);
  endfunction

  function automatic logic [1:0] exp_err2();
    return (m_err > 3) ? 2'd3 : 2'(m_err);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 16'h0;
    m_err = 0;
  endtask

  // Frame semantics from the management-frame rules, default parameters.
  task automatic model_frame(input int pre_total, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] rg,
                             input logic [1:0] ta, input logic [15:0] data);
    e_write = 1'b0;
    e_oe    = 1'b0;
    e_rdata = 16'h0;
    if (pre_total < 32) return;
    if (st != 2'b01 || !(op == 2'b01 || op == 2'b10) || (op == 2'b01 && ta != 2'b10)) begin
      m_err++;
      return;
    end
    if (op == 2'b01) begin
      if ((phy == 5'd1 || phy == 5'd0) && rg < NR) begin
        m_regs[rg] = data;
        e_write    = 1'b1;
      end
    end else begin
      e_oe    = (phy == 5'd1);
      e_rdata = (rg < NR) ? m_regs[rg] : 16'h0;
    end
  endtask

  task automatic observe(input int k);
    if (k >= 14 && bus_m.slave_oe) o_oe_cnt++;
    if (k == 15) o_lead = bus_m.mdio_in;
    if (k >= 16 && k <= 31) o_rd = {o_rd[14:0], bus_m.mdio_in};
    if (wr_strobe_m) begin
      o_strobe_cnt++;
      o_wr_addr = wr_addr_m;
      o_wr_data = wr_data_m;
    end
    if (wr_strobe_np) begin
      o_np_strobe++;
      o_np_addr = wr_addr_np;
      o_np_data = wr_data_np;
    end
  endtask

  // Every frame is followed by two idle ones, which also count as preamble
  // for the next frame (total preamble = pre_len + 2).
  task automatic run_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg,
                           input logic [1:0] ta, input logic [15:0] data);
    logic [31:0] frm;
    frm = {st, op, phy, rg, ta, data};
    o_oe_cnt = 0; o_strobe_cnt = 0; o_np_strobe = 0;
    o_lead = 1'b1; o_rd = '0; o_wr_addr = '0; o_wr_data = '0; o_np_addr = '0; o_np_data = '0;
    repeat (pre_len) begin
      @(negedge mdc);
      m_oe = 1'b1; m_out = 1'b1;
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge mdc);
      observe(k);
      if (op == 2'b10 && k >= 14) begin
        m_oe = 1'b0; m_out = 1'b0;
      end else begin
        m_oe = 1'b1; m_out = frm[31-k];
      end
    end
    @(negedge mdc);
    observe(32);
    m_oe = 1'b1; m_out = 1'b1;
    @(negedge mdc);
    observe(33);
    o_busy_end = busy_m;
    m_oe = 1'b1; m_out = 1'b1;
  endtask

  task automatic do_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                          input logic [4:0] phy, input logic [4:0] rg,
                          input logic [1:0] ta, input logic [15:0] data);
    run_frame(pre_len, st, op, phy, rg, ta, data);
    model_frame(pre_len + 2, st, op, phy, rg, ta, data);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    n_cmp++; if (bus_m.slave_oe !== 1'b0) begin n_err++; $display("FAIL reset_slave_oe: got %b expected 0", bus_m.slave_oe); end
    n_cmp++; if (bus_m.mdio_in !== 1'b0) begin n_err++; $display("FAIL reset_mdio_in: got %b expected 0", bus_m.mdio_in); end
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
    n_cmp++; if (reg_q_m !== '0) begin n_err++; $display("FAIL reset_reg_q: got %h expected 0", reg_q_m); end
    n_cmp++; if (err_m !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d expected 0", err_m); end
    n_cmp++; if ({wr_strobe_m, wr_addr_m, wr_data_m} !== '0) begin n_err++; $display("FAIL reset_wr: got %b/%h/%h expected 0", wr_strobe_m, wr_addr_m, wr_data_m); end
    model_reset();
    @(negedge mdc); rst = 1'b0;
    repeat (2) begin @(negedge mdc); m_oe = 1'b1; m_out = 1'b1; end
  endtask

  task automatic test_write_read();
    do_frame(30, 2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'hA5C3);
    n_cmp++; if (o_strobe_cnt !== 1) begin n_err++; $display("FAIL wr_strobe_pulses: got %0d expected 1", o_strobe_cnt); end
    n_cmp++; if (o_wr_addr !== 5'd3) begin n_err++; $display("FAIL wr_addr: got %0d expected 3", o_wr_addr); end
    n_cmp++; if (o_wr_data !== 16'hA5C3) begin n_err++; $display("FAIL wr_data: got %h expected a5c3", o_wr_data); end
    n_cmp++; if (reg_q_m[63:48] !== 16'hA5C3) begin n_err++; $display("FAIL reg3_value: got %h expected a5c3", reg_q_m[63:48]); end
    do_frame(30, 2'b01, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000);
    n_cmp++; if (o_oe_cnt !== 17) begin n_err++; $display("FAIL read_oe_cycles: got %0d expected 17", o_oe_cnt); end
    n_cmp++; if (o_lead !== 1'b0) begin n_err++; $display("FAIL read_ta_bit: got %b expected 0", o_lead); end
    n_cmp++; if (o_rd !== 16'hA5C3) begin n_err++; $display("FAIL read_data: got %h expected a5c3", o_rd); end
    n_cmp++; if (o_busy_end !== 1'b0) begin n_err++; $display("FAIL read_busy_end: got %b expected 0", o_busy_end); end
  endtask

  task automatic test_addr_filter();
    do_frame(30, 2'b01, 2'b01, 5'd5, 5'd2, 2'b10, 16'h1234);
    n_cmp++; if (o_strobe_cnt !== 0) begin n_err++; $display("FAIL foreign_phy_strobe: got %0d expected 0", o_strobe_cnt); end
    n_cmp++; if (reg_q_m !== model_vec()) begin n_err++; $display("FAIL foreign_phy_regs: got %h expected %h", reg_q_m, model_vec()); end
    do_frame(30, 2'b01, 2'b01, 5'd0, 5'd2, 2'b10, 16'hBEEF);
    n_cmp++; if (o_strobe_cnt !== 1 || o_wr_addr !== 5'd2 || o_wr_data !== 16'hBEEF) begin n_err++; $display("FAIL bcast_write: got %0d/%0d/%h expected 1/2/beef", o_strobe_cnt, o_wr_addr, o_wr_data); end
    n_cmp++; if (reg_q_m[47:32] !== 16'hBEEF) begin n_err++; $display("FAIL bcast_reg2: got %h expected beef", reg_q_m[47:32]); end
    do_frame(30, 2'b01, 2'b10, 5'd0, 5'd2, 2'b11, 16'h0000);
    n_cmp++; if (o_oe_cnt !== 0) begin n_err++; $display("FAIL bcast_read_oe: got %0d expected 0", o_oe_cnt); end
  endtask

  task automatic test_unimpl_reg();
    do_frame(30, 2'b01, 2'b10, 5'd1, 5'd20, 2'b11, 16'h0000);
    n_cmp++; if (o_oe_cnt !== 17 || o_rd !== 16'h0000) begin n_err++; $display("FAIL unimpl_read: got oe=%0d data=%h expected 17/0000", o_oe_cnt, o_rd); end
    do_frame(30, 2'b01, 2'b01, 5'd1, 5'd20, 2'b10, 16'h7777);
    n_cmp++; if (o_strobe_cnt !== 0) begin n_err++; $display("FAIL unimpl_write_strobe: got %0d expected 0", o_strobe_cnt); end
    n_cmp++; if (reg_q_m !== model_vec()) begin n_err++; $display("FAIL unimpl_write_regs: got %h expected %h", reg_q_m, model_vec()); end
  endtask

  task automatic test_short_preamble();
    do_frame(29, 2'b01, 2'b01, 5'd1, 5'd5, 2'b10, 16'hC0DE);
    n_cmp++; if (o_strobe_cnt !== 0) begin n_err++; $display("FAIL short_pre_strobe: got %0d expected 0", o_strobe_cnt); end
    n_cmp++; if (o_busy_end !== 1'b0) begin n_err++; $display("FAIL short_pre_busy: got %b expected 0", o_busy_end); end
    n_cmp++; if (reg_q_m !== model_vec()) begin n_err++; $display("FAIL short_pre_regs: got %h expected %h", reg_q_m, model_vec()); end
    n_cmp++; if (o_np_strobe !== 1 || o_np_addr !== 5'd5 || o_np_data !== 16'hC0DE) begin n_err++; $display("FAIL nopre_write: got %0d/%0d/%h expected 1/5/c0de", o_np_strobe, o_np_addr, o_np_data); end
    n_cmp++; if (reg_q_np[95:80] !== 16'hC0DE) begin n_err++; $display("FAIL nopre_reg5: got %h expected c0de", reg_q_np[95:80]); end
  endtask

  task automatic test_errors();
    int strobes;
    strobes = 0;
    do_frame(30, 2'b01, 2'b11, 5'd1, 5'd1, 2'b10, 16'h1111);
    strobes += o_strobe_cnt;
    do_frame(30, 2'b01, 2'b01, 5'd1, 5'd1, 2'b00, 16'h2222);
    strobes += o_strobe_cnt;
    do_frame(30, 2'b00, 2'b01, 5'd1, 5'd1, 2'b10, 16'h3333);
    strobes += o_strobe_cnt;
    n_cmp++; if (err_m !== 8'd3) begin n_err++; $display("FAIL err_cnt_three: got %0d expected 3", err_m); end
    n_cmp++; if (strobes !== 0) begin n_err++; $display("FAIL err_strobes: got %0d expected 0", strobes); end
    n_cmp++; if (reg_q_m !== model_vec()) begin n_err++; $display("FAIL err_regs: got %h expected %h", reg_q_m, model_vec()); end
    n_cmp++; if (o_busy_end !== 1'b0) begin n_err++; $display("FAIL err_busy_end: got %b expected 0", o_busy_end); end
  endtask

  task automatic test_err_saturate();
    do_frame(30, 2'b01, 2'b00, 5'd1, 5'd1, 2'b10, 16'h4444);
    n_cmp++; if (err_e2 !== 2'd3) begin n_err++; $display("FAIL err2_saturate: got %0d expected 3", err_e2); end
    n_cmp++; if (err_m !== exp_err8()) begin n_err++; $display("FAIL err8_count: got %0d expected %0d", err_m, exp_err8()); end
    do_frame(30, 2'b01, 2'b11, 5'd1, 5'd1, 2'b10, 16'h4444);
    n_cmp++; if (err_e2 !== 2'd3) begin n_err++; $display("FAIL err2_hold: got %0d expected 3", err_e2); end
  endtask

  task automatic test_random();
    logic [1:0]  op, ta;
    logic [4:0]  phy, rg;
    logic [15:0] data;
    int          kind;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      data = 16'($urandom);
      case ($urandom_range(0, 4))
        0, 1:    phy = 5'd1;
        2:       phy = 5'd0;
        3:       phy = 5'd5;
        default: phy = 5'($urandom);
      endcase
      rg = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
      ta = 2'b10;
      if (kind == 0) op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      else if (kind <= 5) op = 2'b01;
      else op = 2'b10;
      if (kind == 1) ta = 2'($urandom_range(0, 1)) | 2'b00;
      do_frame(30 + int'($urandom_range(0, 3)), 2'b01, op, phy, rg, ta, data);
      n_cmp++; if (o_strobe_cnt !== (e_write ? 1 : 0)) begin n_err++; $display("FAIL rnd%0d_strobe: got %0d expected %0d", n, o_strobe_cnt, e_write); end
      if (e_write) begin
        n_cmp++; if (o_wr_addr !== rg || o_wr_data !== data) begin n_err++; $display("FAIL rnd%0d_wr: got %0d/%h expected %0d/%h", n, o_wr_addr, o_wr_data, rg, data); end
      end
      n_cmp++; if (o_oe_cnt !== (e_oe ? 17 : 0)) begin n_err++; $display("FAIL rnd%0d_oe: got %0d expected %0d", n, o_oe_cnt, e_oe ? 17 : 0); end
      if (e_oe) begin
        n_cmp++; if (o_lead !== 1'b0 || o_rd !== e_rdata) begin n_err++; $display("FAIL rnd%0d_rdata: got %b/%h expected 0/%h", n, o_lead, o_rd, e_rdata); end
      end
      n_cmp++; if (reg_q_m !== model_vec()) begin n_err++; $display("FAIL rnd%0d_regs: got %h expected %h", n, reg_q_m, model_vec()); end
      n_cmp++; if (err_m !== exp_err8() || err_e2 !== exp_err2()) begin n_err++; $display("FAIL rnd%0d_err: got %0d/%0d expected %0d/%0d", n, err_m, err_e2, exp_err8(), exp_err2()); end
      n_cmp++; if (o_busy_end !== 1'b0) begin n_err++; $display("FAIL rnd%0d_busy: got %b expected 0", n, o_busy_end); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] frm;
    do_frame(30, 2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'h5A5A);
    frm = {2'b01, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000};
    repeat (30) begin @(negedge mdc); m_oe = 1'b1; m_out = 1'b1; end
    for (int k = 0; k <= 20; k++) begin
      @(negedge mdc);
      if (k >= 14) begin m_oe = 1'b0; m_out = 1'b0; end
      else begin m_oe = 1'b1; m_out = frm[31-k]; end
    end
    n_cmp++; if (bus_m.slave_oe !== 1'b1 || reg_q_m[63:48] !== 16'h5A5A) begin n_err++; $display("FAIL midread_active: got oe=%b reg3=%h expected 1/5a5a", bus_m.slave_oe, reg_q_m[63:48]); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus_m.slave_oe !== 1'b0 || bus_m.mdio_in !== 1'b0) begin n_err++; $display("FAIL midread_rst_bus: got oe=%b in=%b expected 0/0", bus_m.slave_oe, bus_m.mdio_in); end
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL midread_rst_busy: got %b expected 0", busy_m); end
    n_cmp++; if (reg_q_m !== '0 || err_m !== 8'd0) begin n_err++; $display("FAIL midread_rst_state: got regs=%h err=%0d expected 0/0", reg_q_m, err_m); end
    model_reset();
    @(negedge mdc); rst = 1'b0;
    repeat (2) begin @(negedge mdc); m_oe = 1'b1; m_out = 1'b1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_addr_filter();
    test_unimpl_reg();
    test_short_preamble();
    test_errors();
    test_err_saturate();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
